// File: rtl/gemm_tile_dma_if.sv
// -----------------------------------------------------------------------------
// gemm_tile_dma_if
//   Bundles the three data paths of the GEMM tile DMA:
//     - memory port   : mem_en, mem_rdwr (1=write), mem_control (byte count),
//                       mem_addr, mem_wr_data, mem_rd_data (1-cycle latency)
//     - load stream   : ld_valid, ld_ready, ld_data, ld_last
//     - store stream  : st_valid, st_ready, st_data
//   master = the DMA engine, slave = memory plus stream endpoints.
// -----------------------------------------------------------------------------
interface gemm_tile_dma_if #(
  parameter int NUM_RAMS = 16,
  parameter int D_WID    = 8,
  parameter int CNT_W    = 5
);
  localparam int ROW_W = NUM_RAMS * D_WID;

  logic             mem_en;
  logic             mem_rdwr;
  logic [CNT_W-1:0] mem_control;
  logic [31:0]      mem_addr;
  logic [ROW_W-1:0] mem_wr_data;
  logic [ROW_W-1:0] mem_rd_data;

  logic             ld_valid;
  logic             ld_ready;
  logic [ROW_W-1:0] ld_data;
  logic             ld_last;

  logic             st_valid;
  logic             st_ready;
  logic [ROW_W-1:0] st_data;

  modport master (
    output mem_en, mem_rdwr, mem_control, mem_addr, mem_wr_data,
    input  mem_rd_data,
    output ld_valid, ld_data, ld_last,
    input  ld_ready,
    input  st_valid, st_data,
    output st_ready
  );

  modport slave (
    input  mem_en, mem_rdwr, mem_control, mem_addr, mem_wr_data,
    output mem_rd_data,
    input  ld_valid, ld_data, ld_last,
    output ld_ready,
    output st_valid, st_data,
    input  st_ready
  );
endinterface

// File: rtl/gemm_tile_dma.sv
// -----------------------------------------------------------------------------
// gemm_tile_dma
//   Moves a 2-D tile (up to 16 rows x 16 bytes) between the banked GEMM memory
//   and the systolic datapath.
//   LOAD : strided row reads -> 2-entry FIFO -> ld_* valid/ready stream.
//   STORE: st_* valid/ready stream -> strided row writes (combinational path).
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch pulse, honoured in IDLE only
//   dir               0 = LOAD, 1 = STORE (latched at start)
//   base_addr, stride byte address of row 0 and row pitch (latched at start)
//   num_rows          rows to move, 0..16 (latched at start)
//   row_bytes         valid bytes per row, clamped to NUM_RAMS (latched)
//   busy, done        busy in LOAD/STORE; one-cycle done pulse in FIN
//   bus               memory port and both streams (gemm_tile_dma_if.master)
// -----------------------------------------------------------------------------
module gemm_tile_dma #(
  parameter int NUM_RAMS = 16,
  parameter int D_WID    = 8,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      stride,
  input  logic [CNT_W-1:0] num_rows,
  input  logic [CNT_W-1:0] row_bytes,
  output logic             busy,
  output logic             done,
  gemm_tile_dma_if.master  bus
);
  localparam int ROW_W = NUM_RAMS * D_WID;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FIN} state_t;

  state_t           state_q, state_d;

  logic [CNT_W-1:0] n_q;          // rows in this transfer
  logic [CNT_W-1:0] ctrl_q;       // clamped byte count
  logic [31:0]      addr_q;       // address of the next row to issue
  logic [31:0]      stride_q;
  logic [CNT_W-1:0] issued_q;     // reads issued (LOAD) or rows accepted (STORE)
  logic [CNT_W-1:0] popped_q;     // rows handed to the load consumer
  logic             inflight_q;   // read issued last cycle, data arrives now

  logic [ROW_W-1:0] fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;

  logic [CNT_W-1:0] rb_clamped;
  logic [CNT_W-1:0] last_idx;
  logic [1:0]       committed;
  logic             pop, issue_rd, accept;

  assign rb_clamped      = (row_bytes > CNT_W'(NUM_RAMS)) ? CNT_W'(NUM_RAMS) : row_bytes;
  assign last_idx        = n_q - CNT_W'(1);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_control = ctrl_q;

  // NOTE: every state-holding block uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    busy            = 1'b0;
    done            = 1'b0;
    pop             = 1'b0;
    issue_rd        = 1'b0;
    accept          = 1'b0;
    committed       = 2'd0;
    bus.mem_en      = 1'b0;
    bus.mem_rdwr    = 1'b0;
    bus.mem_wr_data = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.ld_last     = 1'b0;
    bus.st_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_rows == '0) state_d = S_FIN;
          else                state_d = dir ? S_STORE : S_LOAD;
        end
      end

      S_LOAD: begin
        busy         = 1'b1;
        bus.ld_valid = (occ_q != 2'd0);
        bus.ld_data  = bus.ld_valid ? fifo_q[rd_ptr_q] : '0;
        bus.ld_last  = bus.ld_valid && (popped_q == last_idx);
        pop          = bus.ld_valid && bus.ld_ready;
        // Slots already spoken for once this cycle's pop leaves: buffered rows
        // plus the read whose data lands this cycle. Crediting the pop lets a
        // read issue every cycle while the consumer keeps up.
        committed    = occ_q - {1'b0, pop} + {1'b0, inflight_q};
        issue_rd     = (issued_q < n_q) && (committed < 2'd2);
        bus.mem_en   = issue_rd;
        if (pop && (popped_q == last_idx)) state_d = S_FIN;
      end

      S_STORE: begin
        busy            = 1'b1;
        bus.st_ready    = (issued_q < n_q);
        accept          = bus.st_ready && bus.st_valid;
        bus.mem_en      = accept;
        bus.mem_rdwr    = accept;
        bus.mem_wr_data = accept ? bus.st_data : '0;
        if (accept && (issued_q == last_idx)) state_d = S_FIN;
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      ctrl_q     <= '0;
      addr_q     <= '0;
      stride_q   <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        n_q        <= num_rows;
        ctrl_q     <= rb_clamped;
        addr_q     <= base_addr;
        stride_q   <= stride;
        issued_q   <= '0;
        popped_q   <= '0;
        inflight_q <= 1'b0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        occ_q      <= 2'd0;
      end
    end else begin
      if (bus.mem_en) begin
        addr_q   <= addr_q + stride_q;
        issued_q <= issued_q + CNT_W'(1);
      end
      inflight_q <= issue_rd;
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        popped_q <= popped_q + CNT_W'(1);
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // NOTE: the row storage has no reset; occupancy is reset instead and ld_data
  // is gated by ld_valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= bus.mem_rd_data;
  end
endmodule

// File: doc/gemm_tile_dma.md
Name: gemm_tile_dma

Overview:
- Initiator on the GEMM banked memory's 16-byte interface port (en/rdwr/control/addr, 1-cycle read latency, byte-aligned and unaligned addressing handled by the memory).
- Moves a 2-D tile of up to 16 rows × 16 bytes between memory and the systolic datapath.
- LOAD direction: reads strided rows and presents them on a valid/ready output stream.
- STORE direction: accepts rows from a valid/ready input stream and writes them to strided addresses.

Parameters:
- NUM_RAMS, 16, bytes per row beat (memory bank count).
- D_WID, 8, bits per byte lane.
- CNT_W, 5, width of row/byte count fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch pulse, sampled in IDLE only.
- dir  in  1  0=LOAD, 1=STORE; latched at start.
- base_addr  in  32  byte address of row 0; latched at start.
- stride  in  32  byte distance between rows; latched at start.
- num_rows  in  CNT_W  rows to move, 0..16; latched at start.
- row_bytes  in  CNT_W  valid bytes per row; latched at start; values >16 clamp to 16.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- mem_en  out  1  interface enable.
- mem_rdwr  out  1  1=write.
- mem_control  out  5  byte count to the memory mask (equals clamped row_bytes).
- mem_addr  out  32  row address.
- mem_wr_data  out  NUM_RAMS*D_WID  write row.
- mem_rd_data  in  NUM_RAMS*D_WID  read row, valid 1 cycle after a read issue.
- ld_valid  out  1  load row available.
- ld_ready  in  1  consumer accepts.
- ld_data  out  NUM_RAMS*D_WID  load row.
- ld_last  out  1  marks final row.
- st_valid  in  1  store row offered.
- st_ready  out  1  block accepts.
- st_data  in  NUM_RAMS*D_WID  store row.

Behaviour:
- Reset: state IDLE, buffer empty, counters 0, all outputs 0 (busy, done, mem_en, mem_rdwr, ld_valid, ld_last, st_ready, mem_control, mem_addr, data buses).
- Reset asserted mid-transfer aborts immediately: no further mem_en, no done pulse, buffered rows discarded.
- States: IDLE, LOAD, STORE, FIN.
- IDLE:
  - start=1 latches all fields and sets the row address register to base_addr.
  - If num_rows=0, go to FIN (no memory access).
  - Otherwise go to LOAD or STORE per dir.
  - start while not IDLE is ignored.
- Address generation:
  - mem_addr = addr register; after each issued row, addr += stride (mod 2^32).
  - mem_control = clamped row_bytes during every access.
- LOAD:
  - Uses a 2-entry FIFO for returned rows.
  - Issue a read (mem_en=1, mem_rdwr=0) only when issued < num_rows and (FIFO occupancy + reads in flight) < 2. At most 1 read is in flight.
  - The row returned the cycle after an issue is pushed into the FIFO. Bytes ≥ row_bytes arrive zero from the memory and are passed through unchanged.
  - ld_valid = FIFO not empty; ld_data = FIFO head.
  - ld_last = 1 when the head is row num_rows-1.
  - The FIFO pops on ld_valid & ld_ready. Push and pop in the same cycle are legal.
  - With ld_ready held high the sustained rate is 1 row/cycle. First ld_valid appears 2 cycles after entering LOAD.
  - After the last row is popped, go to FIN.
- STORE:
  - st_ready = 1 while accepted < num_rows.
  - On st_valid & st_ready, in the same cycle: mem_en=1, mem_rdwr=1, mem_wr_data=st_data, mem_addr=current row address. This is a combinational pass-through.
  - Rate is 1 row/cycle.
  - After the last write is accepted, go to FIN. st_ready drops in the cycle following the last accept.
- FIN: done=1 for one cycle, busy=0, then IDLE. A start in that cycle is ignored.
- busy = 1 in LOAD and STORE.
- mem_en is never asserted in IDLE or FIN.
- row_bytes=0 is legal: LOAD yields all-zero rows; STORE performs masked no-op writes. All beats and the done pulse still occur.

Test Plan:
- LOAD, base=0x100, stride=16, num_rows=4, row_bytes=16, ld_ready=1 → mem reads at 0x100/0x110/0x120/0x130 on consecutive cycles; 4 ld beats with ld_last on the 4th; done 1 cycle after the last pop.
- LOAD, base=0x103 (unaligned), stride=20, num_rows=3, row_bytes=5 → mem_control=5; addrs 0x103/0x117/0x12B; ld_data bytes 5..15 are zero.
- LOAD, num_rows=8, ld_ready toggling 1-0-0-1 → never more than 2 rows buffered/in flight, no row lost or duplicated, order preserved, exactly one done.
- STORE, base=0x200, stride=32, num_rows=3, row_bytes=20, st_valid with gaps → writes at 0x200/0x220/0x240 with mem_control=16; st_ready low after the 3rd accept; done pulse.
- num_rows=0 with start → no mem_en, done 1 cycle after start; start while busy → ignored.
- rst_n low during LOAD row 2 → all outputs 0 at once, no done; a new start after release runs cleanly from base.
